// File: rtl/ram_block_copy_pkg.sv
// Shared definitions for the RAM block-copy engine: width defaults, the
// full-memory word count and the FSM state encoding.
package ram_block_copy_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int WORD_COUNT = 4096;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_READ   = 2'd1;
  localparam state_t ST_WRITE  = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/copy_addr_gen.sv
// Source/destination pointers and remaining-word counter for one copy.
// Direction is fixed when the copy is loaded and stays put until the next load.
module copy_addr_gen
  import ram_block_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] diff;
  logic [ADDR_W-1:0] span_m1;
  logic              dir_back;
  logic              backward;

  // A destination that starts inside the source window would clobber
  // unread source words going forward, so walk it from the top down.
  assign diff     = dst - src;
  assign span_m1  = len[ADDR_W-1:0] - PTR_ONE;
  assign dir_back = (diff != '0) && ({1'b0, diff} < len);
  assign last     = (remaining <= CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      backward  <= 1'b0;
    end else if (load) begin
      backward  <= dir_back;
      src_ptr   <= dir_back ? (src + span_m1) : src;
      dst_ptr   <= dir_back ? (dst + span_m1) : dst;
      remaining <= len;
    end else if (step) begin
      remaining <= remaining - CNT_ONE;
      src_ptr   <= backward ? (src_ptr - PTR_ONE) : (src_ptr + PTR_ONE);
      dst_ptr   <= backward ? (dst_ptr - PTR_ONE) : (dst_ptr + PTR_ONE);
    end
  end

endmodule

// File: rtl/ram_block_copy.sv
// Single-port RAM block copier with memmove semantics: alternates one READ
// and one WRITE cycle per word, then pulses done for one cycle.
module ram_block_copy
  import ram_block_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output state_t            dbg_state
);

  // Handshake: start is a one-cycle request honoured only while idle; src,
  // dst and len are sampled on that edge. busy covers the READ/WRITE cycles
  // and done is a single-cycle pulse in FINISH; no backpressure exists.

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic              last;
  logic              accept;
  logic              step;

  assign accept = (state == ST_IDLE) && start;
  assign step   = (state == ST_WRITE);

  copy_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (CLK),
    .reset   (reset),
    .load    (accept),
    .step    (step),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .src_ptr (src_ptr),
    .dst_ptr (dst_ptr),
    .last    (last)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = (len == '0) ? ST_FINISH : ST_READ;
      ST_READ:   next_state = ST_WRITE;
      ST_WRITE:  next_state = last ? ST_FINISH : ST_READ;
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      data_reg <= '0;
    end else begin
      state <= next_state;
      if (state == ST_READ) data_reg <= ram_out;
    end
  end

  // Outside WRITE the RAM sees the source pointer, so the read data is
  // already valid when READ captures it.
  assign ram_address = (state == ST_WRITE) ? dst_ptr : src_ptr;
  assign ram_in      = data_reg;
  assign ram_load    = (state == ST_WRITE);
  assign busy        = (state == ST_READ) || (state == ST_WRITE);
  assign done        = (state == ST_FINISH);
  assign dbg_state   = state;

endmodule

// File: tb/tb_ram_block_copy.sv
// Bench for ram_block_copy: a 4K-word RAM model, a table of copy vectors with
// an expected read/write queue, and hand-written reset-abort sequence.
module tb_ram_block_copy;
  import ram_block_copy_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  typedef struct {
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [AW:0]   n;
    int            exp_cyc;
    logic [DW-1:0] salt;
  } vec_t;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in;
  logic          ram_load;
  logic [DW-1:0] ram_out;
  state_t        dbg_state;

  logic [DW-1:0] mem     [WORD_COUNT];
  logic [DW-1:0] orig    [WORD_COUNT];
  logic [DW-1:0] exp_img [WORD_COUNT];

  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    rd_q[$];
  logic [AW+DW-1:0] exp_w;
  logic [AW-1:0]    exp_r;

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;
  vec_t vecs[9];

  ram_block_copy #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out),
    .dbg_state   (dbg_state)
  );

  // clock / RAM model
  always #5 CLK = ~CLK;
  always @(posedge CLK) if (ram_load) mem[ram_address] = ram_in;
  assign ram_out = mem[ram_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: reads are busy cycles without ram_load, writes carry load
  always @(negedge CLK) begin
    if (!reset && ram_load) begin
      load_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h expected=none", {ram_address, ram_in});
      end else begin
        exp_w = exp_q.pop_front();
        check("write", {ram_address, ram_in}, exp_w);
      end
    end else if (!reset && busy) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read actual=%0h expected=none", ram_address);
      end else begin
        exp_r = rd_q.pop_front();
        check("read_addr", ram_address, exp_r);
      end
    end
  end

  task automatic preload(input logic [DW-1:0] salt);
    for (int i = 0; i < WORD_COUNT; i++) begin
      mem[i]     = DW'(i) ^ salt;
      orig[i]    = DW'(i) ^ salt;
      exp_img[i] = DW'(i) ^ salt;
    end
  endtask

  task automatic check_image(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < WORD_COUNT; i++) if (mem[i] !== exp_img[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [AW-1:0] diff;
    logic [AW-1:0] a_s;
    logic [AW-1:0] a_d;
    logic          back;
    int            k;
    int            cyc;
    bit            got;
    preload(v.salt);
    diff = v.d - v.s;
    back = (diff != '0) && ({1'b0, diff} < v.n);
    for (int j = 0; j < int'(v.n); j++) begin
      k   = back ? (int'(v.n) - 1 - j) : j;
      a_s = v.s + AW'(k);
      a_d = v.d + AW'(k);
      rd_q.push_back(a_s);
      exp_q.push_back({a_d, orig[a_s]});
      exp_img[a_d] = orig[a_s];
    end
    load_cnt = 0;
    @(posedge CLK); #1;
    start = 1'b1; src = v.s; dst = v.d; len = v.n;
    @(posedge CLK); #1;
    start = 1'b0;
    src = AW'($urandom); dst = AW'($urandom); len = (AW+1)'($urandom_range(0, 4096));
    check("busy_after_start", busy, (v.n != 0));
    cyc = 1;
    got = 0;
    while (cyc <= v.exp_cyc + 10) begin
      if (cyc == 3) start = 1'b0;
      if (done) begin
        got = 1;
        break;
      end
      if (cyc == 2) start = 1'b1;  // must be ignored mid-copy
      @(posedge CLK); #1;
      cyc++;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none expected=%0d", v.exp_cyc);
    end else begin
      check("done_cycle", cyc, v.exp_cyc);
      check("busy_at_done", busy, 0);
    end
    @(posedge CLK); #1;
    check("done_one_cycle", done, 0);
    check("load_count", load_cnt, v.n);
    check("write_q_drained", exp_q.size(), 0);
    check("read_q_drained", rd_q.size(), 0);
    exp_q.delete();
    rd_q.delete();
    check_image("mem_image");
  endtask

  initial begin
    vecs[0] = '{12'h010, 12'h100, 13'd4,    9,    16'h0000};
    vecs[1] = '{12'h000, 12'h002, 13'd4,    9,    16'h0000};
    vecs[2] = '{12'hFFE, 12'h020, 13'd4,    9,    16'h0000};
    vecs[3] = '{12'h050, 12'h060, 13'd0,    1,    16'hA5C3};
    vecs[4] = '{12'h105, 12'h100, 13'd6,    13,   16'h3C3C};
    vecs[5] = '{12'hFFF, 12'h001, 13'd3,    7,    16'h1234};
    vecs[6] = '{12'h123, 12'h123, 13'd3,    7,    16'hBEEF};
    vecs[7] = '{12'h400, 12'h401, 13'd1,    3,    16'h0F0F};
    vecs[8] = '{12'h000, 12'h000, 13'd4096, 8193, 16'h7711};

    preload(16'h0000);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load", ram_load, 0);
    check("rst_addr", ram_address, 0);
    check("rst_data", ram_in, 0);
    check("rst_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge CLK);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // reset during the third WRITE of an 8-word copy
    begin
      int done_seen;
      preload(16'h5A5A);
      rd_q.push_back(12'h200);
      rd_q.push_back(12'h201);
      rd_q.push_back(12'h202);
      exp_q.push_back({12'h300, orig[12'h200]});
      exp_q.push_back({12'h301, orig[12'h201]});
      exp_img[12'h300] = orig[12'h200];
      exp_img[12'h301] = orig[12'h201];
      @(posedge CLK); #1;
      start = 1'b1; src = 12'h200; dst = 12'h300; len = 13'd8;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      check("abort_pre_load", ram_load, 1);
      check("abort_pre_addr", ram_address, 12'h302);
      reset = 1'b1;
      #1;
      check("abort_load", ram_load, 0);
      check("abort_addr", ram_address, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_data", ram_in, 0);
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      done_seen = 0;
      repeat (20) begin
        @(posedge CLK); #1;
        if (done) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      check("abort_write_q", exp_q.size(), 0);
      check("abort_read_q", rd_q.size(), 0);
      exp_q.delete();
      rd_q.delete();
      check_image("abort_mem_image");
    end

    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_block_copy.md
RAM_BLOCK_COPY -- requirements
Module: ram_block_copy

Interface
REQ-001 Parameter: ADDR_W, default 12, RAM word-address width (4096 words).
REQ-002 Parameter: DATA_W, default 16, RAM word width.
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 Port: src  input  ADDR_W  first source word address; sampled with start.
REQ-007 Port: dst  input  ADDR_W  first destination word address; sampled with start.
REQ-008 Port: len  input  ADDR_W+1  word count, 0..4096; sampled with start.
REQ-009 Port: busy  output  1  high from the cycle after accepted start until the cycle before done.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: ram_address  output  ADDR_W  address to RAM.
REQ-012 Port: ram_in  output  DATA_W  write data to RAM.
REQ-013 Port: ram_load  output  1  RAM write enable; RAM writes on the CLK edge while high.
REQ-014 Port: ram_out  input  DATA_W  RAM read data; combinational function of ram_address.

Function
REQ-015 FSM states: IDLE, READ, WRITE, FINISH; encoded as a registered state.
REQ-016 IDLE: start=1 with len>0 -> READ; start=1 with len=0 -> FINISH; otherwise stay.
REQ-017 READ, one cycle: ram_address = current source address, ram_load=0; capture ram_out into data register at edge -> WRITE.
REQ-018 WRITE, one cycle: ram_address = current destination address, ram_in = data register, ram_load=1; decrement remaining count; step addresses; -> READ if remaining>1 before decrement, else FINISH.
REQ-019 FINISH, one cycle: done=1, busy=0 -> IDLE.
REQ-020 Latency: accepted start with len=N>0 yields done exactly 2N+1 cycles after the start edge; len=0 yields done 1 cycle after.
REQ-021 Direction: backward if ((dst - src) mod 2^ADDR_W) is nonzero and < len, else forward; decided at start.
REQ-022 Forward: addresses begin at src/dst and increment by 1 per word.
REQ-023 Backward: addresses begin at src+len-1 / dst+len-1 (mod 2^ADDR_W) and decrement by 1 per word; overlapping copies preserve source data (memmove semantics).
REQ-024 Address arithmetic is modulo 2^ADDR_W; 4095+1 wraps to 0; 0-1 wraps to 4095.
REQ-025 src = dst: copy still executes all 2N cycles (forward), rewriting identical data.
REQ-026 start while not IDLE is ignored; inputs src/dst/len may change after acceptance without effect.
REQ-027 ram_load is high only in WRITE; in all other states ram_in holds the data register and ram_address holds the current source address.

Reset
REQ-028 reset asserted: state=IDLE, busy=0, done=0, ram_load=0, ram_address=0, data register=0, counters=0, asynchronously.
REQ-029 reset mid-copy aborts; words already written stay written; no done pulse is produced.

Structure
REQ-030 Shared package holds the FSM state type, ADDR_W/DATA_W defaults and the 4096 word-count constant.
REQ-031 One sub-module, copy_addr_gen: holds src/dst pointers and remaining count, load/step/direction controls, and outputs the last-word flag.

Verification
REQ-032 Preload mem[i]=i (RAM4K model); start src=0x010 dst=0x100 len=4 -> mem[0x100..0x103]=0x0010..0x0013, done at cycle 9, four ram_load pulses.
REQ-033 Overlap forward-unsafe: mem[i]=i; src=0x000 dst=0x002 len=4 -> backward; mem[2..5]=0,1,2,3; mem[0..1] unchanged.
REQ-034 Wrap: src=0xFFE dst=0x020 len=4 -> reads 0xFFE,0xFFF,0x000,0x001; mem[0x020..0x023] match.
REQ-035 len=0 -> done exactly 1 cycle after start, ram_load never asserted; len=4096 src=0 dst=0 -> done at cycle 8193.
REQ-036 reset pulsed during the 3rd WRITE of len=8 -> outputs zero immediately, only first 2 destination words modified, no done; a subsequent start runs normally.
